// File: rtl/vc_word_rx_pkg.sv
// Shared link parameters for the WRR arbiter, VC table and the word receiver.
package vc_word_rx_pkg;
  localparam int WORD_W     = 4;
  localparam int VC_W       = 2;
  localparam int NUM_VC     = 2 ** VC_W;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(WORD_W);
  localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;
endpackage

// File: rtl/vc_rx_fifo.sv
// Single-clock word FIFO with registered full/empty; a pop frees room for a same-cycle push.
module vc_rx_fifo #(
  parameter int WORD_W     = 4,
  parameter int DEPTH      = 4,
  parameter bit SYNTH_VIEW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          push_ok, pop_ok;

  generate
    if (SYNTH_VIEW) begin : g_synth
      always_comb begin
        pop_ok   = pop & ~empty_q;
        push_ok  = push & (~full_q | pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      end
    end else begin : g_cond
      always_comb begin
        pop_ok   = 1'b0;
        push_ok  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop && !empty_q) begin
          pop_ok   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A full FIFO still accepts the word when its head leaves this cycle.
        if (push && (!full_q || pop_ok)) begin
          push_ok  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_data;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/vc_word_rx.sv
// Deserializes the per-VC serial bit stream into words, queues them per VC, and serves reads.
module vc_word_rx
  import vc_word_rx_pkg::*;
#(
  parameter bit SYNTH_VIEW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic              data_in,
  input  logic [VC_W-1:0]   VC_id,
  input  logic              rd_en,
  input  logic [VC_W-1:0]   rd_vc,
  output logic [WORD_W-1:0] Data_Word_out,
  output logic              rd_valid,
  output logic [NUM_VC-1:0] fifo_full,
  output logic [NUM_VC-1:0] fifo_empty,
  output logic [NUM_VC-1:0] overflow
);
  logic [NUM_VC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_VC-1:0][WORD_W-1:0] shreg_q, shreg_d;
  logic [NUM_VC-1:0][WORD_W-1:0] head;
  logic [NUM_VC-1:0]             push, pop;
  logic [WORD_W-1:0]             push_word;
  logic [NUM_VC-1:0]             overflow_q, overflow_d;
  logic [WORD_W-1:0]             data_word_q, data_word_d;
  logic                          rd_valid_q, rd_valid_d;
  logic                          pop_ok;

  // Only one VC owns the link per cycle, so a single push word serves all FIFOs.
  always_comb begin
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = '0;
    push_word = {data_in, shreg_q[VC_id][WORD_W-2:0]};
    if (data_valid) begin
      shreg_d[VC_id][cnt_q[VC_id]] = data_in;
      cnt_d[VC_id]                 = cnt_q[VC_id] + 1'b1;
      if (cnt_q[VC_id] == CNT_W'(WORD_W - 1)) push[VC_id] = 1'b1;
    end
  end

  always_comb begin
    pop         = '0;
    pop[rd_vc]  = rd_en;
    pop_ok      = rd_en && !fifo_empty[rd_vc];
    rd_valid_d  = pop_ok;
    data_word_d = pop_ok ? head[rd_vc] : data_word_q;
    // A full FIFO is never empty, so a same-VC pop always makes room.
    overflow_d  = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      shreg_q     <= '0;
      overflow_q  <= '0;
      data_word_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_d;
      data_word_q <= data_word_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      vc_rx_fifo #(
        .WORD_W    (WORD_W),
        .DEPTH     (FIFO_DEPTH),
        .SYNTH_VIEW(SYNTH_VIEW)
      ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push[v]),
        .push_data(push_word),
        .pop      (pop[v]),
        .head     (head[v]),
        .full     (fifo_full[v]),
        .empty    (fifo_empty[v])
      );
    end
  endgenerate

  assign Data_Word_out = data_word_q;
  assign rd_valid      = rd_valid_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_vc_word_rx.sv
// Directed bench for vc_word_rx: deserialization, interleave, overflow, simultaneous push/pop, reset.
module tb_vc_word_rx;
  logic       clk = 1'b0;
  logic       reset, data_valid, data_in, rd_en;
  logic [1:0] VC_id, rd_vc;
  logic [3:0] Data_Word_out, fifo_full, fifo_empty, overflow;
  logic       rd_valid;
  int         n_tests = 0;
  int         n_fail  = 0;

  vc_word_rx dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .VC_id(VC_id),
    .rd_en(rd_en), .rd_vc(rd_vc), .Data_Word_out(Data_Word_out), .rd_valid(rd_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; data_valid = 1'b0; data_in = 1'b0; VC_id = '0; rd_en = 1'b0; rd_vc = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic [1:0] vc, input logic b);
    data_valid = 1'b1; VC_id = vc; data_in = b;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] vc, input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(vc, w[i]);
  endtask

  task automatic rd(input logic [1:0] vc);
    rd_en = 1'b1; rd_vc = vc;
    tick();
    rd_en = 1'b0;
  endtask

  logic [3:0] t3_words [4] = '{4'h3, 4'hA, 4'h5, 4'hC};

  initial begin
    do_reset();
    chk("rst_empty", fifo_empty, 4'hF);
    chk("rst_full", fifo_full, 4'h0);
    chk("rst_ovf", overflow, 4'h0);
    chk("rst_word", Data_Word_out, 4'h0);
    chk("rst_rdv", rd_valid, 1'b0);

    // 1: VC2 bits 1,0,1,1 -> 4'b1101
    send_bit(2'd2, 1'b1); send_bit(2'd2, 1'b0); send_bit(2'd2, 1'b1);
    chk("t1_empty_before", fifo_empty[2], 1'b1);
    send_bit(2'd2, 1'b1);
    chk("t1_empty_after", fifo_empty[2], 1'b0);
    rd(2'd2);
    chk("t1_word", Data_Word_out, 4'b1101);
    chk("t1_rdv", rd_valid, 1'b1);
    chk("t1_empty_drained", fifo_empty[2], 1'b1);
    tick();
    chk("t1_rdv_pulse", rd_valid, 1'b0);
    chk("t1_word_hold", Data_Word_out, 4'b1101);

    // 2: interleave VC0 1,1,1,1 with VC3 0,0,0,1
    for (int i = 0; i < 4; i++) begin
      send_bit(2'd0, 1'b1);
      send_bit(2'd3, (i == 3));
    end
    chk("t2_empty", fifo_empty, 4'b0110);
    rd(2'd0);
    chk("t2_vc0", Data_Word_out, 4'hF);
    rd(2'd3);
    chk("t2_vc3", Data_Word_out, 4'h8);
    chk("t2_empty_end", fifo_empty, 4'hF);
    // other VCs' counters stayed at 0: a fresh VC1 word lands aligned
    send_word(2'd1, 4'h6);
    rd(2'd1);
    chk("t2_vc1_aligned", Data_Word_out, 4'h6);

    // 3: fill VC1, overflow on the 5th word, drain in order
    for (int i = 0; i < 4; i++) send_word(2'd1, t3_words[i]);
    chk("t3_full", fifo_full[1], 1'b1);
    chk("t3_no_ovf_yet", overflow[1], 1'b0);
    send_word(2'd1, 4'h9);
    chk("t3_ovf", overflow, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      rd(2'd1);
      chk($sformatf("t3_rd%0d", i), Data_Word_out, t3_words[i]);
    end
    chk("t3_empty", fifo_empty[1], 1'b1);
    chk("t3_ovf_sticky", overflow[1], 1'b1);

    // 4: full VC1, last bit of a new word coincides with a pop
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(2'd1, 4'(i));
    send_bit(2'd1, 1'b1); send_bit(2'd1, 1'b1); send_bit(2'd1, 1'b1);
    data_valid = 1'b1; VC_id = 2'd1; data_in = 1'b0; rd_en = 1'b1; rd_vc = 2'd1;
    tick();
    data_valid = 1'b0; rd_en = 1'b0;
    chk("t4_no_ovf", overflow[1], 1'b0);
    chk("t4_full", fifo_full[1], 1'b1);
    chk("t4_pop_oldest", Data_Word_out, 4'h1);
    for (int i = 0; i < 4; i++) begin
      rd(2'd1);
      chk($sformatf("t4_rd%0d", i), Data_Word_out, (i == 3) ? 32'h7 : 32'(i + 2));
    end

    // 5: read on an empty VC is ignored
    rd(2'd2);
    chk("t5_rdv", rd_valid, 1'b0);
    chk("t5_word_hold", Data_Word_out, 4'h7);

    // push and pop on the same empty FIFO: pop ignored, push lands
    send_bit(2'd2, 1'b0); send_bit(2'd2, 1'b1); send_bit(2'd2, 1'b0);
    data_valid = 1'b1; VC_id = 2'd2; data_in = 1'b1; rd_en = 1'b1; rd_vc = 2'd2;
    tick();
    data_valid = 1'b0; rd_en = 1'b0;
    chk("t5b_rdv", rd_valid, 1'b0);
    chk("t5b_empty", fifo_empty[2], 1'b0);
    rd(2'd2);
    chk("t5b_word", Data_Word_out, 4'hA);

    // 6: reset mid-word discards the partial bits
    send_bit(2'd0, 1'b1); send_bit(2'd0, 1'b1);
    do_reset();
    chk("t6_empty", fifo_empty, 4'hF);
    chk("t6_full", fifo_full, 4'h0);
    chk("t6_ovf", overflow, 4'h0);
    chk("t6_word", Data_Word_out, 4'h0);
    chk("t6_rdv", rd_valid, 1'b0);
    send_bit(2'd0, 1'b0); send_bit(2'd0, 1'b1);
    chk("t6_partial_empty", fifo_empty[0], 1'b1);
    send_bit(2'd0, 1'b1); send_bit(2'd0, 1'b0);
    chk("t6_complete", fifo_empty[0], 1'b0);
    rd(2'd0);
    chk("t6_word_new", Data_Word_out, 4'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
